// File: rtl/dice_frame_sequencer_if.sv
// dice_frame_sequencer_if: pixel stream, bank write port, correlation handshake and frame status.
// The master side is the camera/engine environment and the slave side is the sequencer.
interface dice_frame_sequencer_if #(
    parameter int ADDR_W = 17
);
    logic [31:0]       pix_data;
    logic              pix_valid;
    logic              pix_sof;
    logic              pix_ready;
    logic              wr_en;
    logic              wr_bank;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              corr_start;
    logic              corr_done;
    logic              corr_busy;
    logic [31:0]       frame_counter;
    logic              ref_bank;
    logic              def_bank;
    logic              swap;
    logic              frame_err;

    modport master (
        output pix_data, pix_valid, pix_sof, corr_done,
        input  pix_ready, wr_en, wr_bank, wr_addr, wr_data, corr_start, corr_busy,
        input  frame_counter, ref_bank, def_bank, swap, frame_err
    );

    modport slave (
        input  pix_data, pix_valid, pix_sof, corr_done,
        output pix_ready, wr_en, wr_bank, wr_addr, wr_data, corr_start, corr_busy,
        output frame_counter, ref_bank, def_bank, swap, frame_err
    );
endinterface

// File: rtl/dice_frame_sequencer.sv
// dice_frame_sequencer: captures frames into ping-pong banks, tracks ref/def roles
// and launches the correlation engine once two frames are resident.
module dice_frame_sequencer #(
    parameter int IMG_W  = 232,
    parameter int IMG_H  = 448,
    parameter int ADDR_W = 17
) (
    input logic                   clk,
    input logic                   rst_n,
    dice_frame_sequencer_if.slave bus
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_LAUNCH  = 2'd2;
    localparam logic [1:0] S_CORR    = 2'd3;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d, beat_addr;
    logic              bank_q, bank_d;
    logic [31:0]       frame_counter_q, frame_counter_d, count_inc;
    logic              ref_q, ref_d, def_q, def_d;
    logic              wr_en_q, wr_bank_q, frame_err_q, corr_start_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;
    logic              ready, accept, write, last, restart;

    always_comb begin
        ready           = (state_q == S_IDLE) || (state_q == S_CAPTURE);
        accept          = bus.pix_valid && ready;
        write           = accept && (bus.pix_sof || state_q == S_CAPTURE);
        restart         = accept && bus.pix_sof && state_q == S_CAPTURE;
        beat_addr       = bus.pix_sof ? '0 : addr_q;
        last            = write && beat_addr == LAST_ADDR;
        // Wrapping to 2 keeps "two frames resident" true and preserves parity.
        count_inc       = (frame_counter_q == 32'hFFFF_FFFF) ? 32'd2 : frame_counter_q + 32'd1;
        addr_d          = write ? (last ? '0 : beat_addr + ADDR_W'(1)) : addr_q;
        frame_counter_d = last ? count_inc : frame_counter_q;
        bank_d          = last ? ~bank_q : bank_q;
        def_d           = last ? bank_q : def_q;
        ref_d           = (last && count_inc >= 32'd2) ? ~bank_q : ref_q;
        case (state_q)
            S_IDLE, S_CAPTURE: state_d = write ? (last ? S_LAUNCH : S_CAPTURE) : state_q;
            S_LAUNCH:          state_d = (frame_counter_q >= 32'd2) ? S_CORR : S_IDLE;
            default:           state_d = bus.corr_done ? S_IDLE : S_CORR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            addr_q          <= '0;
            bank_q          <= 1'b0;
            frame_counter_q <= 32'd0;
            ref_q           <= 1'b0;
            def_q           <= 1'b0;
            wr_en_q         <= 1'b0;
            wr_bank_q       <= 1'b0;
            wr_addr_q       <= '0;
            wr_data_q       <= 32'd0;
            frame_err_q     <= 1'b0;
            corr_start_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            bank_q          <= bank_d;
            frame_counter_q <= frame_counter_d;
            ref_q           <= ref_d;
            def_q           <= def_d;
            wr_en_q         <= write;
            frame_err_q     <= restart;
            corr_start_q    <= state_q == S_LAUNCH && frame_counter_q >= 32'd2;
            if (write) begin
                wr_bank_q <= bank_q;
                wr_addr_q <= beat_addr;
                wr_data_q <= bus.pix_data;
            end
        end
    end

    always_comb begin
        bus.pix_ready     = ready;
        bus.wr_en         = wr_en_q;
        bus.wr_bank       = wr_bank_q;
        bus.wr_addr       = wr_addr_q;
        bus.wr_data       = wr_data_q;
        bus.corr_start    = corr_start_q;
        bus.corr_busy     = state_q == S_CORR;
        bus.frame_counter = frame_counter_q;
        bus.ref_bank      = ref_q;
        bus.def_bank      = def_q;
        bus.swap          = ref_q;
        bus.frame_err     = frame_err_q;
    end
endmodule
